// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: depth/width helpers and the
// access-case enumeration used by the occupancy counter.
package fifo_pkg;

  // Number of entries for a given address width; every entry is usable.
  function automatic int fifo_depth(input int abits);
    return 1 << abits;
  endfunction

  // Occupancy counter width: one extra bit so the value DEPTH is representable.
  function automatic int fifo_cnt_w(input int abits);
    return abits + 1;
  endfunction

  // Counter width for the default 4-bit address configuration.
  localparam int CNT_W = fifo_cnt_w(4);

  // Accepted-access case, encoded as {wr_acc, rd_acc}.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    POP      = 2'b01,
    PUSH     = 2'b10,
    PUSH_POP = 2'b11
  } acc_e;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: DEPTH x DBITS array with a
// synchronous write port. The read port is registered (data appears the
// cycle after re) unless FIFO_FWFT_EN is defined, in which case it is a
// plain asynchronous read of raddr.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int ABITS = 4,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ABITS);

  logic [DBITS-1:0] mem [DEPTH];

  // Write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  logic unused_rd_ctl;
  assign unused_rd_ctl = ^{rst_n, re};

  assign rdata = mem[raddr];
`else
  logic [DBITS-1:0] rdata_q;
  logic [DBITS-1:0] rdata_d;

  // Hold the last popped word; load the old contents of raddr on a read
  // (read-before-write when the same address is written this cycle).
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Registered read data, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/fifo_sync_ctr.sv
// Synchronous FIFO with occupancy counter, almost-full/almost-empty flags,
// sticky overflow/underflow errors and synchronous flush.
// Optional macro FIFO_FWFT_EN selects first-word fall-through reads.
//
// Handshake: a write is taken when wr=1 and the FIFO is not full, or is
// full but a read is taken in the same cycle; a read is taken when rd=1 and
// the FIFO is not empty. Requests that are not taken change nothing except
// the sticky error flags. flush overrides both requests.
module fifo_sync_ctr
  import fifo_pkg::*;
#(
  parameter int ABITS    = 4,
  parameter int DBITS    = 8,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr,
  input  logic [DBITS-1:0] din,
  input  logic             rd,
  output logic [DBITS-1:0] dout,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ABITS:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int                     DEPTH   = fifo_depth(ABITS);
  localparam int                     CW      = fifo_cnt_w(ABITS);
  localparam logic [CW-1:0]          DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]          AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]          AE_C    = CW'(AE_LEVEL);

  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ae_q, ae_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;
  acc_e             acc;
  logic [DBITS-1:0] ram_rdata;

  // Accept decisions; flush suppresses any access in its cycle.
  always_comb begin
    wr_acc = wr & (~full_q | rd) & ~flush;
    rd_acc = rd & ~empty_q & ~flush;
    acc    = acc_e'({wr_acc, rd_acc});
  end

  // Next pointers, count, flags (from next count) and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case (acc)
      PUSH:    count_d = count_q + 1'b1;
      POP:     count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A set event in the same cycle as clr_err keeps the flag set.
    ovf_d = clr_err ? 1'b0 : ovf_q;
    udf_d = clr_err ? 1'b0 : udf_q;
    if (wr & full_q & ~rd) ovf_d = 1'b1;
    if (rd & empty_q)      udf_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(
    .ABITS (ABITS),
    .DBITS (DBITS)
  ) u_ram (
    .clk   (clock),
    .rst_n (reset),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign dout     = empty_q ? '0 : ram_rdata;
  assign rd_valid = ~empty_q;
`else
  logic rd_valid_q, rd_valid_d;

  // One-cycle strobe following each accepted read.
  always_comb begin
    rd_valid_d = rd_acc;
  end

  // Read-valid strobe register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_valid_q <= 1'b0;
    else        rd_valid_q <= rd_valid_d;
  end

  assign dout     = ram_rdata;
  assign rd_valid = rd_valid_q;
`endif

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
